// File: rtl/param_fifo_pkg.sv
// Shared defaults for the parametrised FIFO and its dual-port RAM.
package param_fifo_pkg;

  // Default geometry: 4-bit words, 8 entries.
  localparam int unsigned FIFO_DATA_W   = 4;
  localparam int unsigned FIFO_ADDR_W   = 3;

  // Default flag thresholds on the occupancy count.
  localparam int unsigned FIFO_AF_LEVEL = 6;
  localparam int unsigned FIFO_AE_LEVEL = 1;

  // Number of entries addressed by an addr_w-bit pointer.
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/dram_dp.sv
// Parametrised dual-port RAM: one write port (A) and one registered read port (B).
// A read and a write to the same address on the same edge return the old word.
module dram_dp
  import param_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] q_b
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_b_q;

  // Storage array: written on port A, never reset.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= data_a;
    end
  end

  // Read register: samples the pre-write array contents, holds when not reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_b_q <= '0;
    end else if (re_b) begin
      q_b_q <= mem[addr_b];
    end
  end

  assign q_b = q_b_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO built on dram_dp.
// Holds read/write pointers, occupancy count, full/empty and almost flags.
// Optional sticky overflow/underflow flag enabled by defining PARAM_FIFO_ERR_EN;
// without it fifo_err is tied low.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DATA_W,
  parameter int unsigned ADDR_W   = FIFO_ADDR_W,
  parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
  parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              fifo_err
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CNT_AE   = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q;
  logic              push_ok, pop_ok;

  // Accept/reject decisions and next-state for pointers and count.
  // A push at full is accepted only when a pop frees the slot on the same edge;
  // a pop at empty is always rejected, so there is no fall-through path.
  always_comb begin
    push_ok  = push & (~full | pop);
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and read-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= pop_ok;
    end
  end

  dram_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we_a   (push_ok),
    .addr_a (wr_ptr_q),
    .data_a (data_in),
    .re_b   (pop_ok),
    .addr_b (rd_ptr_q),
    .q_b    (data_out)
  );

  // Flags decode from the count register only: no input-to-output paths.
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign count        = count_q;
  assign valid_out    = valid_q;

`ifdef PARAM_FIFO_ERR_EN
  logic err_q;
  logic err_set;

  // Overflow is a push at full with no pop to make room; underflow is any pop at empty.
  assign err_set = (push & full & ~pop) | (pop & empty);

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign fifo_err = err_q;
`else
  assign fifo_err = 1'b0;
`endif

endmodule
